data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, word capacity of storage (power of two, >=4).
REQ-002 Parameter LATENCY, default 2, cycles from request accept edge to resp_valid rising (legal 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert supplied externally.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_wr  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, little-endian lanes.
REQ-010 req_be  input  4  store byte enables, bit i gates byte lane i.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator accepts response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned or out-of-range access.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept occurs on an edge where req_valid and req_ready are both 1; addr, wdata, be, wr SHALL be latched at that edge.
REQ-017 On accept: LATENCY=1 -> RESP; else -> WAIT with counter loaded LATENCY-2; WAIT decrements each cycle and moves to RESP on the edge where counter is 0.
REQ-018 resp_valid SHALL be 1 exactly in RESP, first asserted LATENCY cycles after the accept edge.
REQ-019 Error when addr[1:0]!=0 or addr[31:2] >= DEPTH_WORDS; error responses: resp_err=1, resp_rdata=0, no storage change.
REQ-020 Store write SHALL occur on the edge entering RESP, only enabled lanes updated; req_be=0 store completes with no change and resp_err=0.
REQ-021 Load data SHALL be captured on the edge entering RESP and reflect all previously completed stores.
REQ-022 resp_rdata and resp_err SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-023 Response handshake (resp_valid & resp_ready) SHALL return FSM to IDLE; req_ready rises the following cycle (no same-edge re-accept); peak throughput one transaction per LATENCY+1 cycles.
REQ-024 Request inputs SHALL be ignored outside IDLE; resp_ready ignored outside RESP.

Reset
REQ-025 While rst=0: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
REQ-026 Reset during WAIT SHALL discard the pending transaction; a store not yet in RESP SHALL not modify storage.
REQ-027 Storage contents SHALL not be reset; contents undefined until written.

Structure
REQ-028 Package mem_resp_pkg SHALL hold state enum (IDLE/WAIT/RESP), WORD_BYTES=4, default DEPTH_WORDS and LATENCY constants.
REQ-029 Storage SHALL be a sub-module mem_word_array: synchronous single-port DEPTH_WORDS x 32 RAM with 4-bit byte write enable, write-first not required.
REQ-030 FSM, counter, latch registers and error decode SHALL reside in data_mem_responder.

Verification
REQ-031 Reset then store addr 0x10, wdata 0xDEADBEEF, be 0xF, resp_ready=1 -> resp_valid rises 2 cycles after accept, resp_err=0, resp_rdata=0; then load 0x10 -> resp_rdata=0xDEADBEEF.
REQ-032 Store 0x10 be 0x2 wdata 0x0000AA00 over 0xDEADBEEF -> load 0x10 returns 0xDEADAAEF.
REQ-033 Load addr 0x13 and load addr 0x400 (DEPTH 256) -> resp_err=1, resp_rdata=0; store 0x400 leaves word 0 unchanged.
REQ-034 Load with resp_ready=0 for 5 cycles -> resp_valid, rdata, err stable, req_ready=0 throughout; req_ready=1 the cycle after resp_ready=1.
REQ-035 Store 0x20 0x12345678, rst=0 during WAIT -> outputs at reset values immediately; subsequent load 0x20 does not return 0x12345678 unless previously written.
REQ-036 LATENCY=1 and LATENCY=4 builds, back-to-back requests -> resp_valid exactly LATENCY cycles after each accept, accepts spaced LATENCY+1 cycles.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared constants, FSM state encoding and request payload for the data memory responder.
package mem_resp_pkg;

    localparam int unsigned WORD_BYTES      = 4;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DEF_DEPTH_WORDS = 256;
    localparam int unsigned DEF_LATENCY     = 2;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_W-1:0]     wdata;
        logic [WORD_BYTES-1:0] be;
    } req_s;

endpackage

// File: rtl/mem_word_array.sv
// Synchronous single-port word RAM with per-byte write enables and a registered read port.
module mem_word_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic                           clk,
    input  logic                           i_en,
    input  logic [WORD_BYTES-1:0]          i_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [DATA_W-1:0]              i_wdata,
    output logic [DATA_W-1:0]              o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;

    // Contents are intentionally not reset; read data only moves on an enabled access.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < int'(WORD_BYTES); b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with fixed request-to-response latency.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DEF_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [WORD_BYTES-1:0] req_be,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam bit          SINGLE = (LATENCY == 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    req_s             r_req;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic             r_rdata_sel;

    req_s              w_live;
    req_s              w_cur;
    logic              w_accept;
    logic              w_to_resp;
    logic              w_err;
    logic              w_ram_en;
    logic              w_rd_hit;
    logic [WORD_BYTES-1:0] w_ram_we;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_live   = '{wr: req_wr, addr: req_addr, wdata: req_wdata, be: req_be};
    assign w_accept = req_valid & r_req_ready;

    // With single-cycle latency the access happens on the accept edge, so use the live request.
    assign w_cur     = (r_state == IDLE) ? w_live : r_req;
    assign w_to_resp = ((r_state == IDLE) && w_accept && SINGLE) ||
                       ((r_state == WAIT) && (r_cnt == '0));

    assign w_err    = (w_cur.addr[1:0] != 2'b00) ||
                      (w_cur.addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS));
    assign w_ram_en = w_to_resp & ~w_err;
    assign w_ram_we = w_cur.wr ? w_cur.be : '0;
    assign w_rd_hit = w_to_resp & ~w_err & ~w_cur.wr;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_cur.addr[AW+1:2]),
        .i_wdata (w_cur.wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_req        <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata_sel  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req       <= w_live;
                        r_req_ready <= 1'b0;
                        if (SINGLE) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_err;
                            r_rdata_sel  <= w_rd_hit;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_W'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                        r_rdata_sel  <= w_rd_hit;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_rdata_sel  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    // RAM read register holds between accesses, so gating it with a flop keeps rdata stable.
    assign resp_rdata = r_rdata_sel ? w_ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instances built with LATENCY 2, 1 and 4.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_wr     [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [3:0]  req_be     [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_wr(req_wr[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
    );

    function automatic int lat_of(input int d);
        if (d == 0) return 2;
        if (d == 1) return 1;
        return 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete transaction with resp_ready held high; returns data, error and latency.
    task automatic do_txn(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic err, output int lat);
        int guard = 0;
        @(negedge clk);
        req_valid[d] = 1'b1; req_wr[d] = wr; req_addr[d] = addr;
        req_wdata[d] = wdata; req_be[d] = be; resp_ready[d] = 1'b1;
        while (!req_ready[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("req_ready_timeout", 32'(guard), 32'd0);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (!resp_valid[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata[d];
        err   = resp_err[d];
        @(posedge clk); #1;
    endtask

    task automatic txn_check(input string tag, input int d, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic [31:0] exp_rdata,
                             input logic exp_err);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        do_txn(d, wr, addr, wdata, be, rdata, err, lat);
        check({tag, "_lat"},   32'(lat),   32'(lat_of(d)));
        check({tag, "_err"},   32'(err),   32'(exp_err));
        check({tag, "_rdata"}, rdata,      exp_rdata);
    endtask

    // Hold req_valid and resp_ready high; record accept edges and resp_valid rises.
    task automatic throughput(input int d, input string tag);
        int acc[$];
        int rise[$];
        int p = 0;
        logic prev_rv = 1'b0;
        int l = lat_of(d);
        @(negedge clk);
        req_valid[d] = 1'b1; req_wr[d] = 1'b0; req_addr[d] = 32'h0000_0008;
        req_be[d] = 4'h0; resp_ready[d] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (resp_valid[d] && !prev_rv) rise.push_back(p);
            prev_rv = resp_valid[d];
            if (req_ready[d]) acc.push_back(p + 1);
            @(posedge clk);
            p++;
            @(negedge clk);
        end
        req_valid[d] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check({tag, "_counts"}, 32'((acc.size() >= 3) && (rise.size() >= 2)), 32'd1);
        if (acc.size() >= 3 && rise.size() >= 2) begin
            check({tag, "_lat0"},  32'(rise[0] + 1 - acc[0]), 32'(l));
            check({tag, "_lat1"},  32'(rise[1] + 1 - acc[1]), 32'(l));
            check({tag, "_gap01"}, 32'(acc[1] - acc[0]),      32'(l + 1));
            check({tag, "_gap12"}, 32'(acc[2] - acc[1]),      32'(l + 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int guard;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_be[d] = '0; resp_ready[d] = 1'b0;
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  32'(req_ready[0]),  32'd1);
        check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_rdata",      resp_rdata[0],      32'd0);
        check("rst_err",        32'(resp_err[0]),   32'd0);
        @(negedge clk);
        rst = 1'b1;

        txn_check("st10",       0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
        txn_check("ld10",       0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
        txn_check("st10_be2",   0, 1'b1, 32'h10,  32'h0000AA00, 4'h2, 32'h0,        1'b0);
        txn_check("ld10_merge", 0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADAAEF, 1'b0);
        txn_check("st00",       0, 1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0);
        txn_check("ld13_mis",   0, 1'b0, 32'h13,  32'h0,        4'h0, 32'h0,        1'b1);
        txn_check("ld400_oor",  0, 1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1);
        txn_check("st400_oor",  0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1);
        txn_check("ld00_keep",  0, 1'b0, 32'h0,   32'h0,        4'h0, 32'hCAFEF00D, 1'b0);
        txn_check("st10_be0",   0, 1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0);
        txn_check("st11_mis",   0, 1'b1, 32'h11,  32'h00000000, 4'hF, 32'h0,        1'b1);
        txn_check("ld10_keep",  0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADAAEF, 1'b0);
        txn_check("st3fc_top",  0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0);
        txn_check("ld3fc_top",  0, 1'b0, 32'h3FC, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0);

        // Backpressured load; a competing request is presented and must be ignored.
        @(negedge clk);
        req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 32'h3FC; resp_ready[0] = 1'b0;
        @(posedge clk); #1;
        req_wr[0] = 1'b1; req_addr[0] = 32'h10; req_wdata[0] = 32'h0; req_be[0] = 4'hF;
        guard = 0;
        while (!resp_valid[0] && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid",     32'(resp_valid[0]), 32'd1);
            check("hold_rdata",     resp_rdata[0],      32'hA5A5A5A5);
            check("hold_err",       32'(resp_err[0]),   32'd0);
            check("hold_req_ready", 32'(req_ready[0]),  32'd0);
        end
        @(negedge clk);
        req_valid[0] = 1'b0; resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("release_req_ready",  32'(req_ready[0]),  32'd1);
        check("release_resp_valid", 32'(resp_valid[0]), 32'd0);
        txn_check("ld10_ignored", 0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0);

        // Reset while a store waits: outputs clear at once and storage is untouched.
        txn_check("st20", 0, 1'b1, 32'h20, 32'h11111111, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 32'h20;
        req_wdata[0] = 32'h12345678; req_be[0] = 4'hF; resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("wait_req_ready", 32'(req_ready[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("wrst_req_ready",  32'(req_ready[0]),  32'd1);
        check("wrst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("wrst_rdata",      resp_rdata[0],      32'd0);
        check("wrst_err",        32'(resp_err[0]),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        txn_check("ld20_after_rst", 0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11111111, 1'b0);

        txn_check("l1_st08", 1, 1'b1, 32'h8, 32'h01020304, 4'hF, 32'h0,        1'b0);
        txn_check("l1_ld08", 1, 1'b0, 32'h8, 32'h0,        4'h0, 32'h01020304, 1'b0);
        txn_check("l4_st08", 2, 1'b1, 32'h8, 32'h0A0B0C0D, 4'hF, 32'h0,        1'b0);
        txn_check("l4_ld08", 2, 1'b0, 32'h8, 32'h0,        4'h0, 32'h0A0B0C0D, 1'b0);
        txn_check("l4_ld401",2, 1'b0, 32'h401, 32'h0,      4'h0, 32'h0,        1'b1);

        throughput(0, "thr_l2");
        throughput(1, "thr_l1");
        throughput(2, "thr_l4");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
